// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locking arbiter feeding the write port of an async FIFO
module fifo_wr_arbiter #(
  parameter int NumReq   = 4,
  parameter int Width    = 8,
  parameter int MaxBurst = 4
) (
  input  logic                    clk_wr,
  input  logic                    rst_n,
  input  logic [NumReq-1:0]       i_req_valid,
  input  logic [NumReq*Width-1:0] i_req_data,
  output logic [NumReq-1:0]       o_req_ready,
  output logic [NumReq-1:0]       o_grant,
  output logic                    o_wr_en,
  output logic [Width-1:0]        o_wr_data,
  input  logic                    i_full
);
  localparam int LW = $clog2(NumReq);
  typedef enum logic {IDLE, BURST} state_t;
  state_t           state;
  logic [LW-1:0]    last, win, sel;
  logic [LW:0]      sum;
  logic [7:0]       count;
  logic             found, hold_valid, can_accept, xfer;
  logic [Width-1:0] hold_data;
  // first valid requester after last, wrapping modulo NumReq
  always_comb begin
    win = last;
    found = 1'b0;
    sum = '0;
    for (int i = 1; i <= NumReq; i++) begin
      sum = {1'b0, last} + (LW+1)'(i);
      sum = sum >= (LW+1)'(NumReq) ? sum - (LW+1)'(NumReq) : sum;
      if (!found && i_req_valid[LW'(sum)]) begin
        found = 1'b1;
        win = LW'(sum);
      end
    end
  end
  // in a burst the owner is always last, so last doubles as the owner register
  assign sel         = state == BURST ? last : win;
  assign o_grant     = (rst_n && (state == BURST || found)) ? {{(NumReq-1){1'b0}}, 1'b1} << sel : '0;
  assign can_accept  = ~hold_valid | ~i_full;
  assign o_req_ready = o_grant & {NumReq{can_accept}};
  assign xfer        = |(o_req_ready & i_req_valid);
  assign o_wr_en     = hold_valid & ~i_full;
  assign o_wr_data   = hold_data;
  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= LW'(NumReq - 1);
      count      <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      if (xfer) begin
        hold_data  <= i_req_data[sel*Width +: Width];
        hold_valid <= 1'b1;
      end else if (o_wr_en) hold_valid <= 1'b0;
      if (state == IDLE) begin
        if (xfer) begin
          last <= win;
          if (MaxBurst > 1) begin
            state <= BURST;
            count <= 8'd1;
          end
        end
      end else if (xfer) begin
        count <= count + 8'd1;
        state <= count + 8'd1 == 8'(MaxBurst) ? IDLE : BURST;
      end else if (!i_req_valid[last]) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, MB = 4;
  logic clk = 0, rst_n = 0, full = 0;
  logic [N-1:0] vld = '0, rdy, g, rdy1, g1, on = '0, acc = '0;
  logic [N*W-1:0] data;
  logic we, we1;
  logic [W-1:0] wd, wd1;
  int total = 0, bad = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] base[N];
  logic [5:0] seq[N], wexp[N];
  int left[N];
  bit rnd = 0, tagchk = 0;
  int vprob = 60, fprob = 30;
  logic [N-1:0] g_s, r_s, g1_s;
  logic we_s, we1_s;
  logic [W-1:0] wd_s, wd1_s;

  always #5 clk = ~clk;
  for (genvar k = 0; k < N; k++) assign data[k*W +: W] = base[k] + {2'b00, seq[k]};

  fifo_wr_arbiter #(.NumReq(N), .Width(W), .MaxBurst(MB)) dut (
    .clk_wr(clk), .rst_n(rst_n), .i_req_valid(vld), .i_req_data(data), .o_req_ready(rdy),
    .o_grant(g), .o_wr_en(we), .o_wr_data(wd), .i_full(full));
  fifo_wr_arbiter #(.NumReq(N), .Width(W), .MaxBurst(1)) dut1 (
    .clk_wr(clk), .rst_n(rst_n), .i_req_valid(vld), .i_req_data(data), .o_req_ready(rdy1),
    .o_grant(g1), .o_wr_en(we1), .o_wr_data(wd1), .i_full(full));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) vld[r] = rnd ? ($urandom_range(99) < vprob) : (on[r] && left[r] != 0);
    if (rnd) full = $urandom_range(99) < fprob;
  endtask

  task automatic cyc();
    logic [W-1:0] e;
    @(negedge clk);
    g_s = g; r_s = rdy; we_s = we; wd_s = wd; g1_s = g1; we1_s = we1; wd1_s = wd1;
    acc = rdy & vld;
    chk("ready_onehot", $countones(rdy) <= 1, 1);
    if (full) chk("wr_en_full", we, 0);
    if (we) begin
      if (sb.size() == 0) chk("wr_unexpected", we, 0);
      else begin
        e = sb.pop_front();
        chk("wr_data", wd, e);
      end
      if (tagchk) begin
        chk("req_order", wd[5:0], wexp[wd[7:6]]);
        wexp[wd[7:6]] = wd[5:0] + 6'd1;
      end
    end
    for (int r = 0; r < N; r++) if (acc[r]) sb.push_back(data[r*W +: W]);
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) if (acc[r]) begin
      seq[r]++;
      if (left[r] > 0) left[r]--;
    end
    drive();
  endtask

  task automatic do_reset();
    rst_n = 0; rnd = 0; tagchk = 0; full = 0; on = '0;
    sb.delete();
    for (int r = 0; r < N; r++) begin
      base[r] = W'(r << 6); seq[r] = '0; left[r] = -1; wexp[r] = '0;
    end
    drive();
    #1;
    chk("rst_grant", g, 0); chk("rst_ready", rdy, 0); chk("rst_wr_en", we, 0);
    chk("rst_wr_data", wd, 0); chk("rst_grant1", g1, 0); chk("rst_wr_en1", we1, 0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    do_reset();
    cyc();
    chk("idle_grant", g_s, 0); chk("idle_wr_en", we_s, 0);
    // all requesters streaming: bursts of MB, round robin from requester 0
    on = '1; drive();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t1_grant", g_s, 1 << ((i / 4) % 4));
      chk("t1_wr_en", we_s, i > 0);
    end
    // per-beat arbitration on the MaxBurst=1 instance
    do_reset();
    on = 4'b1010; drive();
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t2_grant", g1_s, (i % 2) ? 8 : 2);
      if (i > 0) begin
        chk("t2_wr_en", we1_s, 1);
        chk("t2_wr_tag", wd1_s[7:6], (i % 2) ? 1 : 3);
      end
    end
    // requester 2 drops valid mid-burst, release goes past it to requester 3
    do_reset();
    left[2] = 2; on = 4'b0100; drive();
    cyc(); chk("t3_grant0", g_s, 4);
    cyc(); chk("t3_grant1", g_s, 4);
    on = 4'b1110; drive();
    cyc(); chk("t3_hold_grant", g_s, 4); chk("t3_no_xfer", acc, 0);
    cyc(); chk("t3_next", g_s, 8);
    // full backpressure with one word held
    do_reset();
    base[0] = 8'hA0; on = 4'b0001; full = 1; drive();
    cyc(); chk("t4_accept", r_s, 1); chk("t4_wr_en0", we_s, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_ready", r_s, 0); chk("t4_wr_en", we_s, 0); chk("t4_hold", wd_s, 8'hA0);
    end
    full = 0;
    cyc(); chk("t4_resume_we", we_s, 1); chk("t4_resume_d", wd_s, 8'hA0); chk("t4_resume_rdy", r_s, 1);
    cyc(); chk("t4_d1", wd_s, 8'hA1);
    cyc(); chk("t4_d2", wd_s, 8'hA2);
    // asynchronous reset mid-burst with a held word
    do_reset();
    on = 4'b1110; drive();
    cyc(); cyc();
    chk("t5_pre_we", we, 1); chk("t5_pre_grant", g, 2);
    #2 rst_n = 0;
    #1;
    chk("t5_async_we", we, 0); chk("t5_async_grant", g, 0); chk("t5_async_data", wd, 0);
    sb.delete();
    on = '1; drive();
    @(posedge clk);
    #1 rst_n = 1;
    cyc(); chk("t5_first", g_s, 1);
    // random valids and full against the scoreboard
    do_reset();
    tagchk = 1; rnd = 1; drive();
    for (int i = 0; i < 400; i++) cyc();
    rnd = 0; on = '0; full = 0; drive();
    for (int i = 0; i < 4; i++) cyc();
    chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of the asynchronous FIFO between NumReq requesters in the write clock domain. Each requester offers words over a valid/ready handshake; the arbiter grants one requester at a time, optionally locks the grant for a bounded burst, and drives the FIFO write enable and data from a one-word holding register that respects the FIFO full flag.

## Interface
Parameters:
- NumReq, 4: number of requesters, 2..16.
- Width, 8: data width, equal to the FIFO Width.
- MaxBurst, 4: maximum beats per grant, 1..255. With 1, arbitration is per beat.

Ports:
- clk_wr  input  1  write-domain clock, the only clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_req_valid  input  NumReq  per-requester word valid.
- i_req_data  input  NumReq*Width  requester r's word in bits [r*Width +: Width].
- o_req_ready  output  NumReq  per-requester accept, at most one bit high.
- o_grant  output  NumReq  one-hot current owner, zero when idle.
- o_wr_en  output  1  FIFO write enable.
- o_wr_data  output  Width  FIFO write data.
- i_full  input  1  FIFO full flag, already in the clk_wr domain.

## Operation
- Holding register: hold_data and hold_valid. The FIFO write is o_wr_en = hold_valid & ~i_full, combinational. o_wr_data = hold_data.
- can_accept = ~hold_valid | ~i_full. A beat transfers from requester r on an edge where o_req_ready[r] & i_req_valid[r].
- o_req_ready[r] = o_grant[r] & can_accept. In IDLE, ready depends on the other requesters' valids through the arbitration.
- On accept, hold_data loads the beat and hold_valid is set. Otherwise, if o_wr_en, hold_valid clears.
- Priority pointer last (log2 NumReq bits) holds the most recent grant owner. The search order is last+1, last+2, …, last, modulo NumReq.
- State IDLE:
  - o_grant is the first valid requester in search order, combinationally, or zero if none is valid.
  - A transfer moves to BURST with owner set to the winner, count=1, and last=winner.
  - If MaxBurst==1, the FSM stays in IDLE and only last updates.
  - If there is no transfer (no valid, or ~can_accept), the FSM stays in IDLE and last is unchanged.
- State BURST:
  - o_grant = onehot(owner), independent of other valids.
  - A transfer increments count. If the new count == MaxBurst, the next state is IDLE.
  - If i_req_valid[owner] is low, the next state is IDLE with no transfer that cycle.
  - If the owner is valid but ~can_accept, the FSM stays in BURST and the stall does not count.
- count width is 8 bits and never exceeds MaxBurst.
- Data ordering per requester is preserved. Words from different requesters interleave only at grant boundaries.

## Timing
- Reset values: hold_valid=0, hold_data=0, state=IDLE, count=0, last=NumReq-1 (requester 0 wins first). Outputs: o_wr_en=0, o_wr_data=0, o_grant=0, o_req_ready=0 while no valid is present.
- Latency: a beat accepted at edge k appears on o_wr_data after k. o_wr_en is high in cycle k+1 if ~i_full, so the FIFO write occurs at edge k+1.
- Throughput: one beat per cycle while the FIFO is not full. A simultaneous FIFO write and new accept on the same edge is the normal steady state.
- Full: while hold_valid & i_full, all ready bits are low and hold is frozen. The cycle after i_full falls, o_wr_en rises and ready returns.
- Full with hold empty: one beat is still accepted into hold. It waits there, so no beat is ever dropped.
- Grant changes take effect in the cycle after the releasing edge. There is no idle bubble when another requester is valid.
- Reset mid-operation: asynchronous assertion clears the hold word (discarded) and any burst immediately. Outputs go to reset values without waiting for a clock edge.

## Test plan
- Reset, then requesters 0..3 all continuously valid, MaxBurst=4, i_full=0 → grants are 0,0,0,0,1,1,1,1,2,… and o_wr_en is high every cycle from the second accept cycle onward, with data in order.
- MaxBurst=1, requesters 1 and 3 valid → o_grant alternates 1,3,1,3 each cycle. FIFO write sequence matches the alternation.
- Requester 2 sends 2 beats then drops valid mid-burst (MaxBurst=4) → release after the valid-low cycle. Next grant goes to the next valid requester after 2, and last=2.
- i_full forced high for 5 cycles while requester 0 streams 0xA0,0xA1,… → exactly one word is held, ready is low for 5 cycles, o_wr_en=0 throughout. After release, 0xA1,0xA2… are written with none lost or duplicated.
- rst_n pulsed low mid-burst with hold_valid=1 → o_wr_en and o_grant drop asynchronously. After release, requester 0 is granted first.
- Scoreboard against the FIFO read side under random valids and random i_full → per-requester order is preserved, every accepted beat is written exactly once, and no burst exceeds MaxBurst.
